rr_arbiter_burst_lock: RTL and testbench



---
 rtl/rr_arbiter_burst_lock_if.sv | 21 ++
 rtl/rr_arbiter_burst_lock.sv | 116 +++++++++++
 tb/tb_rr_arbiter_burst_lock.sv | 132 +++++++++++++
 3 files changed

// File: rtl/rr_arbiter_burst_lock_if.sv
// Request/grant bundle between N bus masters and the burst-lock arbiter.
interface rr_arbiter_burst_lock_if #(
    parameter int N = 4
);
    logic [N-1:0]         req;
    logic                 done;
    logic [N-1:0]         grant;
    logic                 grant_valid;
    logic [$clog2(N)-1:0] grant_id;
    logic                 preempt;

    modport master (
        output req, done,
        input  grant, grant_valid, grant_id, preempt
    );

    modport slave (
        input  req, done,
        output grant, grant_valid, grant_id, preempt
    );
endinterface

// File: rtl/rr_arbiter_burst_lock.sv
// N-way round-robin arbiter whose winner keeps a registered grant for a whole burst.
// Define RR_ARB_PREEMPT_EN to revoke a grant after MAX_HOLD cycles with a preempt pulse.
module rr_arbiter_burst_lock #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8
) (
    input logic                    clk,
    input logic                    rst,
    rr_arbiter_burst_lock_if.slave bus
);
    // state  | meaning
    // IDLE   | no owner, grant all zeros
    // LOCKED | grant_id owns the resource until done, req drop or timeout
    localparam int IW = $clog2(N);
    typedef enum logic {IDLE, LOCKED} state_t;

    if (N < 2 || MAX_HOLD < 1) begin : g_bad_param
        $error("rr_arbiter_burst_lock: need N >= 2 and MAX_HOLD >= 1");
    end

    state_t        state, state_nxt;
    logic [N-1:0]  grant_q, grant_nxt;
    logic [IW-1:0] id_q, id_nxt;
    logic [IW-1:0] ptr_q, ptr_nxt, ptr_inc, arb_ptr;
    logic [IW-1:0] idx, win;
    logic [N-1:0]  arb_req, excl;
    logic          found, drop, timeout, rel;
    logic          preempt_q, preempt_nxt;
`ifdef RR_ARB_PREEMPT_EN
    localparam int HW = $clog2(MAX_HOLD + 1);
    logic [HW-1:0] hold_q, hold_nxt;
`endif

    assign ptr_inc = (id_q == IW'(N - 1)) ? '0 : id_q + 1'b1;

    always_comb begin
        state_nxt   = state;
        grant_nxt   = grant_q;
        id_nxt      = id_q;
        ptr_nxt     = ptr_q;
        arb_ptr     = ptr_q;
        excl        = '0;
        found       = 1'b0;
        win         = '0;
        idx         = '0;
        timeout     = 1'b0;
        preempt_nxt = 1'b0;
`ifdef RR_ARB_PREEMPT_EN
        hold_nxt    = hold_q;
`endif
        drop = (state == LOCKED) && (bus.done || !bus.req[id_q]);
`ifdef RR_ARB_PREEMPT_EN
        // done wins over a coincident timeout, so no preempt in that case
        timeout = (state == LOCKED) && !drop && (hold_q == HW'(MAX_HOLD));
`endif
        rel = drop || timeout;
        if (rel) begin
            ptr_nxt    = ptr_inc;
            arb_ptr    = ptr_inc;
            excl[id_q] = drop;
        end
        arb_req = bus.req & ~excl;

        for (int k = 0; k < N; k++) begin
            idx = IW'((int'(arb_ptr) + k) % N);
            if (!found && arb_req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end

        if (state == IDLE || rel) begin
            grant_nxt      = '0;
            grant_nxt[win] = found;
            id_nxt         = found ? win : '0;
            state_nxt      = found ? LOCKED : IDLE;
            preempt_nxt    = timeout;
`ifdef RR_ARB_PREEMPT_EN
            hold_nxt       = found ? HW'(1) : '0;
        end else begin
            hold_nxt = (hold_q == HW'(MAX_HOLD)) ? hold_q : hold_q + 1'b1;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            grant_q   <= '0;
            id_q      <= '0;
            ptr_q     <= '0;
            preempt_q <= 1'b0;
`ifdef RR_ARB_PREEMPT_EN
            hold_q    <= '0;
`endif
        end else begin
            state     <= state_nxt;
            grant_q   <= grant_nxt;
            id_q      <= id_nxt;
            ptr_q     <= ptr_nxt;
            preempt_q <= preempt_nxt;
`ifdef RR_ARB_PREEMPT_EN
            hold_q    <= hold_nxt;
`endif
        end
    end

    assign bus.grant       = grant_q;
    assign bus.grant_valid = |grant_q;
    assign bus.grant_id    = id_q;
`ifdef RR_ARB_PREEMPT_EN
    assign bus.preempt     = preempt_q;
`else
    assign bus.preempt     = 1'b0;
`endif
endmodule

// File: tb/tb_rr_arbiter_burst_lock.sv
// Directed-vector bench for rr_arbiter_burst_lock (N=4, MAX_HOLD=4).
module tb_rr_arbiter_burst_lock;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    rr_arbiter_burst_lock_if #(.N(4)) bus ();

    rr_arbiter_burst_lock #(.N(4), .MAX_HOLD(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       done;
        logic [3:0] grant;
        logic [1:0] id;
    } vec_t;

    vec_t tv[$];

    task automatic add(input logic r, input logic [3:0] q, input logic d,
                       input logic [3:0] g, input logic [1:0] i);
        vec_t v;
        v.rst = r; v.req = q; v.done = d; v.grant = g; v.id = i;
        tv.push_back(v);
    endtask

    task automatic check(input string name, input logic [3:0] g, input logic [1:0] i,
                         input logic p);
        logic [7:0] got, exp;
        got = {bus.grant, bus.grant_valid, bus.grant_id, bus.preempt};
        exp = {g, |g, i, p};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got grant=%b valid=%b id=%0d preempt=%b, expected grant=%b valid=%b id=%0d preempt=%b",
                     name, bus.grant, bus.grant_valid, bus.grant_id, bus.preempt, g, |g, i, p);
        end
    endtask

    task automatic step(input logic r, input logic [3:0] q, input logic d);
        rst      = r;
        bus.req  = q;
        bus.done = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.req  = '0;
        bus.done = 1'b0;

        // reset
        add(1, 4'b0000, 0, 4'b0000, 0);
        // full request, done in 2nd cycle of each grant, wrap 3 -> 0
        add(0, 4'b1111, 0, 4'b0001, 0);
        add(0, 4'b1111, 0, 4'b0001, 0);
        add(0, 4'b1111, 1, 4'b0010, 1);
        add(0, 4'b1111, 0, 4'b0010, 1);
        add(0, 4'b1111, 1, 4'b0100, 2);
        add(0, 4'b1111, 0, 4'b0100, 2);
        add(0, 4'b1111, 1, 4'b1000, 3);
        add(0, 4'b1111, 0, 4'b1000, 3);
        add(0, 4'b1111, 1, 4'b0001, 0);
        add(0, 4'b1111, 0, 4'b0001, 0);
        // owner 0 done with 0011 -> direct hand-over to 1
        add(0, 4'b0011, 1, 4'b0010, 1);
        add(0, 4'b0011, 0, 4'b0010, 1);
        add(0, 4'b0000, 0, 4'b0000, 0);
        // single requester 2, drop, then pointer=3 picks 3 over 0
        add(0, 4'b0100, 0, 4'b0100, 2);
        add(0, 4'b0100, 0, 4'b0100, 2);
        add(0, 4'b0100, 0, 4'b0100, 2);
        add(0, 4'b0000, 0, 4'b0000, 0);
        add(0, 4'b1001, 0, 4'b1000, 3);
        add(0, 4'b1011, 0, 4'b1000, 3);
        add(0, 4'b0011, 0, 4'b0001, 0);
        // done together with req drop counts once
        add(0, 4'b0010, 1, 4'b0010, 1);
        // owner excluded after done, nobody else -> idle
        add(0, 4'b0010, 1, 4'b0000, 0);
        add(0, 4'b0000, 1, 4'b0000, 0);
        // reset mid-burst, then pointer back to 0
        add(0, 4'b0100, 0, 4'b0100, 2);
        add(0, 4'b0100, 0, 4'b0100, 2);
        add(1, 4'b0100, 0, 4'b0000, 0);
        add(0, 4'b1111, 0, 4'b0001, 0);

        foreach (tv[n]) begin
            step(tv[n].rst, tv[n].req, tv[n].done);
            check($sformatf("vec%0d", n), tv[n].grant, tv[n].id, 1'b0);
        end

`ifdef RR_ARB_PREEMPT_EN
        step(1, 4'b0000, 0);
        for (int c = 1; c <= 16; c++) begin
            int o;
            o = ((c - 1) / 4) % 2;
            step(0, 4'b0011, 0);
            check($sformatf("timeout_alt c%0d", c), (o == 1) ? 4'b0010 : 4'b0001,
                  2'(o), (c > 1) && ((c - 1) % 4 == 0));
        end
        step(0, 4'b0011, 1);
        check("done_on_timeout", 4'b0001, 0, 1'b0);

        step(1, 4'b0000, 0);
        for (int c = 1; c <= 12; c++) begin
            step(0, 4'b0001, 0);
            check($sformatf("timeout_solo c%0d", c), 4'b0001, 0,
                  (c > 1) && ((c - 1) % 4 == 0));
        end
`else
        step(1, 4'b0000, 0);
        for (int c = 1; c <= 20; c++) begin
            step(0, 4'b0011, 0);
            check($sformatf("no_timeout c%0d", c), 4'b0001, 0, 1'b0);
        end
        step(0, 4'b0011, 1);
        check("long_burst_done", 4'b0010, 1, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
